// File: rtl/aq_sigcap_pkg.sv
// aq_sigcap_pkg: shared widths, capture FSM states and the RAM write-enable constant.
package aq_sigcap_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam logic [3:0] MEM_WE_ALL = 4'hF;
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;
endpackage

// File: rtl/aq_sigcap_trig.sv
// aq_sigcap_trig: mask/value compare OR force, qualified by an accepted ARMED sample.
// AQ_SIGCAP_TRIG_EDGE_EN makes the compare fire only on a false->true transition.
module aq_sigcap_trig import aq_sigcap_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_eval,
    input  logic [DATA_W-1:0] i_din,
    input  logic [DATA_W-1:0] i_mask,
    input  logic [DATA_W-1:0] i_val,
    input  logic              i_force,
    output logic              o_hit
);
    logic w_match;
    assign w_match = ((i_din ^ i_val) & i_mask) == '0;
`ifdef AQ_SIGCAP_TRIG_EDGE_EN
    logic r_prev;
    logic w_prev;
    // a START in the same cycle as the sample sees a cleared history
    assign w_prev = i_clr ? 1'b0 : r_prev;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_prev <= 1'b0;
        else if (i_eval) r_prev <= w_match;
        else if (i_clr) r_prev <= 1'b0;
    assign o_hit = i_eval & (i_force | (w_match & ~w_prev));
`else
    logic w_unused;
    assign w_unused = ^{clk, rst, i_clr};
    assign o_hit = i_eval & (i_force | w_match);
`endif
endmodule

// File: rtl/aq_sigcap_capture.sv
// aq_sigcap_capture: armed ring-buffer capture into the signal-capture RAM with mask/value trigger
// and post-trigger count. Optional edge-sensitive trigger via AQ_SIGCAP_TRIG_EDGE_EN.
module aq_sigcap_capture import aq_sigcap_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic [ADDR_W-1:0] POST_CNT,
    input  logic [DATA_W-1:0] TRIG_MASK,
    input  logic [DATA_W-1:0] TRIG_VAL,
    input  logic              TRIG_FORCE,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [3:0]        MEM_WE,
    output logic [DATA_W-1:0] MEM_DI,
    output logic              BUSY,
    output logic              DONE,
    output logic              WRAPPED,
    output logic [ADDR_W-1:0] TRIG_ADDR,
    output logic [ADDR_W-1:0] END_ADDR
);
    state_t r_state, w_next;
    logic [ADDR_W-1:0] r_ptr, r_post_cnt, r_cnt, w_ptr, w_cnt_src;
    logic [DATA_W-1:0] r_mask, r_val, w_mask, w_val;
    logic r_we, w_start, w_stop, w_arm_smp, w_post_smp, w_write, w_hit, w_trig;

    assign w_start    = START & ~STOP;
    assign w_stop     = STOP & (START | r_state == S_ARMED | r_state == S_POST);
    // a sample arriving with START belongs to the new capture and is trigger-evaluated
    assign w_arm_smp  = DIN_VALID & (w_start | (~STOP & r_state == S_ARMED));
    assign w_post_smp = DIN_VALID & ~START & ~STOP & r_state == S_POST;
    assign w_write    = w_arm_smp | w_post_smp;
    assign w_trig     = w_arm_smp & w_hit;
    assign w_ptr      = w_start ? '0 : r_ptr;
    assign w_cnt_src  = w_start ? POST_CNT : r_post_cnt;
    assign w_mask     = w_start ? TRIG_MASK : r_mask;
    assign w_val      = w_start ? TRIG_VAL : r_val;

    aq_sigcap_trig #(.DATA_W(DATA_W)) u_trig (
        .clk(CLK), .rst(RST), .i_clr(w_start), .i_eval(w_arm_smp), .i_din(DIN),
        .i_mask(w_mask), .i_val(w_val), .i_force(TRIG_FORCE), .o_hit(w_hit)
    );

    always_ff @(posedge CLK or posedge RST)
        if (RST) r_state <= S_IDLE;
        else r_state <= w_next;

    always_comb
        w_next = w_stop ? S_IDLE :
                 w_trig ? (w_cnt_src == '0 ? S_DONE : S_POST) :
                 w_start ? S_ARMED :
                 (w_post_smp && r_cnt == ADDR_W'(1)) ? S_DONE : r_state;

    always_comb begin
        BUSY   = r_state == S_ARMED || r_state == S_POST;
        DONE   = r_state == S_DONE;
        MEM_WE = r_we ? MEM_WE_ALL : 4'h0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_we       <= 1'b0;
            r_ptr      <= '0;
            r_post_cnt <= '0;
            r_cnt      <= '0;
            r_mask     <= '0;
            r_val      <= '0;
            MEM_ADDR   <= '0;
            MEM_DI     <= '0;
            WRAPPED    <= 1'b0;
            TRIG_ADDR  <= '0;
            END_ADDR   <= '0;
        end else begin
            r_we <= w_write;
            if (w_start) begin
                r_mask     <= TRIG_MASK;
                r_val      <= TRIG_VAL;
                r_post_cnt <= POST_CNT;
                r_ptr      <= '0;
                WRAPPED    <= 1'b0;
            end
            if (w_write) begin
                r_ptr    <= w_ptr + 1'b1;
                MEM_ADDR <= w_ptr;
                MEM_DI   <= DIN;
                END_ADDR <= w_ptr;
                if (&w_ptr) WRAPPED <= 1'b1;
            end
            if (w_trig) begin
                TRIG_ADDR <= w_ptr;
                r_cnt     <= w_cnt_src;
            end else if (w_post_smp) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule
